// File: rtl/box_renderer.sv
// box_renderer
//
// Turns each new vertical position of the game box into a burst of VGA
// adapter pixel writes. On every game tick it first repaints the box at its
// previous position in the background colour, then paints it at the new
// position in the box colour. It runs on the fast system clock and emits
// one pixel per cycle.
//
// Ports:
//   clk          system clock (pixel-write rate)
//   resetn       asynchronous, active-low reset
//   frame_tick   one-cycle pulse per game tick (clk domain)
//   y_coordinate top row of the box, from the position register
//   x_out        pixel column to the VGA adapter
//   y_out        pixel row to the VGA adapter
//   colour       pixel colour to the VGA adapter
//   plot         write strobe; x_out/y_out/colour form a valid pixel while high
//   busy         high whenever the FSM is not in IDLE
//   frame_done   one-cycle pulse when a frame update completes
//
// Handshake: frame_tick is a request with no back-pressure. It is accepted
// only on an edge where busy is low; a tick seen while busy is high is
// dropped, never queued. plot is a pure valid strobe: the adapter cannot
// stall the renderer, so each pixel is presented for exactly one cycle.

module box_renderer #(
  parameter logic [7:0] BOX_X      = 8'd30,
  parameter int         BOX_SIZE   = 4,
  parameter logic [2:0] BOX_COLOUR = 3'b110,
  parameter logic [2:0] BG_COLOUR  = 3'b000,
  parameter logic [6:0] Y_MAX      = 7'd119
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic [6:0] y_coordinate,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done
);

  // Highest top row that still keeps the whole box on screen.
  localparam logic [6:0] Y_TOP_MAX = 7'(int'(Y_MAX) - BOX_SIZE + 1);
  localparam logic [3:0] LAST_IDX  = 4'(BOX_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [3:0] row, row_n;
  logic [3:0] col, col_n;
  logic [6:0] new_y, new_y_n;
  logic [6:0] old_y, old_y_n;
  logic       old_valid, old_valid_n;
  logic [7:0] x_n;
  logic [6:0] y_n;
  logic [2:0] colour_n;
  logic       plot_n;
  logic       busy_n;
  logic       frame_done_n;
  logic       last_px;

  assign last_px = (row == LAST_IDX) && (col == LAST_IDX);

  always_comb begin
    state_n      = state;
    row_n        = row;
    col_n        = col;
    new_y_n      = new_y;
    old_y_n      = old_y;
    old_valid_n  = old_valid;
    x_n          = x_out;
    y_n          = y_out;
    colour_n     = colour;
    plot_n       = 1'b0;
    frame_done_n = 1'b0;

    case (state)
      IDLE: begin
        if (frame_tick) begin
          // Upstream can overshoot the bottom edge; pin the box on screen.
          new_y_n = (y_coordinate > Y_TOP_MAX) ? Y_TOP_MAX : y_coordinate;
          row_n   = 4'd0;
          col_n   = 4'd0;
          // Nothing has been drawn since reset, so there is nothing to erase.
          state_n = old_valid ? ERASE : DRAW;
        end
      end

      ERASE, DRAW: begin
        plot_n   = 1'b1;
        x_n      = BOX_X + {4'd0, col};
        y_n      = ((state == ERASE) ? old_y : new_y) + {3'd0, row};
        colour_n = (state == ERASE) ? BG_COLOUR : BOX_COLOUR;
        if (last_px) begin
          row_n   = 4'd0;
          col_n   = 4'd0;
          state_n = (state == ERASE) ? DRAW : DONE;
        end else if (col == LAST_IDX) begin
          col_n = 4'd0;
          row_n = row + 4'd1;
        end else begin
          col_n = col + 4'd1;
        end
      end

      DONE: begin
        frame_done_n = 1'b1;
        old_y_n      = new_y;
        old_valid_n  = 1'b1;
        state_n      = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // busy is registered from the next state so it tracks the state register.
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      row        <= 4'd0;
      col        <= 4'd0;
      new_y      <= 7'd0;
      old_y      <= 7'd0;
      old_valid  <= 1'b0;
      x_out      <= 8'd0;
      y_out      <= 7'd0;
      colour     <= 3'd0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      row        <= row_n;
      col        <= col_n;
      new_y      <= new_y_n;
      old_y      <= old_y_n;
      old_valid  <= old_valid_n;
      x_out      <= x_n;
      y_out      <= y_n;
      colour     <= colour_n;
      plot       <= plot_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_box_renderer.sv
// tb_box_renderer
//
// Directed bench for box_renderer with default parameters. Each frame is
// launched by a single frame_tick; the expected pixel stream (erase pixels
// then draw pixels, row-major) is built into exp_q and compared against
// every cycle where plot is high. Frame timing (first/last plot cycle and
// the frame_done cycle relative to the tick edge) is checked per frame.

module tb_box_renderer;

  logic       clk;
  logic       resetn;
  logic       frame_tick;
  logic [6:0] y_coordinate;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       frame_done;

  int n_compared;
  int n_mismatched;

  // Pixel packing: {colour, x, y}
  logic [17:0] exp_q[$];

  box_renderer dut (
    .clk         (clk),
    .resetn      (resetn),
    .frame_tick  (frame_tick),
    .y_coordinate(y_coordinate),
    .x_out       (x_out),
    .y_out       (y_out),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- scoreboard model ----------------
  task automatic push_box(input logic [6:0] top, input logic [2:0] col_val);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        exp_q.push_back({col_val, 8'(30 + c), 7'(int'(top) + r)});
      end
    end
  endtask

  // ---------------- driver ----------------
  // Issues one tick with y_in and watches 45 cycles. tick_a/tick_b are
  // cycle offsets (relative to the accepted tick edge) at which extra ticks
  // are sampled; 0 disables them. y_coordinate is scrambled mid-frame.
  task automatic run_frame(input string name, input logic [6:0] y_in, input bit do_erase,
                           input logic [6:0] old_top, input int tick_a, input int tick_b);
    logic [6:0]  top;
    logic [17:0] exp_px;
    int first_plot, last_plot, n_plot, n_done, done_cycle, exp_plots;
    top        = (y_in > 7'd116) ? 7'd116 : y_in;
    exp_plots  = do_erase ? 32 : 16;
    first_plot = 0;
    last_plot  = 0;
    n_plot     = 0;
    n_done     = 0;
    done_cycle = 0;
    exp_q.delete();
    if (do_erase) push_box(old_top, 3'b000);
    push_box(top, 3'b110);

    @(negedge clk);
    y_coordinate = y_in;
    frame_tick   = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    check_val({name, "_busy_start"}, 32'(busy), 32'd1);

    for (int j = 1; j <= 45; j++) begin
      @(posedge clk);
      #1;
      if (plot) begin
        n_plot++;
        if (first_plot == 0) first_plot = j;
        last_plot = j;
        if (exp_q.size() > 0) begin
          exp_px = exp_q.pop_front();
          check_val($sformatf("%s_px%0d", name, n_plot), 32'({colour, x_out, y_out}), 32'(exp_px));
        end
      end
      if (frame_done) begin
        n_done++;
        done_cycle = j;
      end
      frame_tick   = ((j + 1) == tick_a) || ((j + 1) == tick_b);
      y_coordinate = 7'(j * 3);
    end
    frame_tick = 1'b0;

    check_val({name, "_first_plot"}, 32'(first_plot), 32'd1);
    check_val({name, "_last_plot"}, 32'(last_plot), 32'(exp_plots));
    check_val({name, "_n_plot"}, 32'(n_plot), 32'(exp_plots));
    check_val({name, "_n_done"}, 32'(n_done), 32'd1);
    check_val({name, "_done_cycle"}, 32'(done_cycle), 32'(exp_plots + 1));
    check_val({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check_val({name, "_busy_end"}, 32'(busy), 32'd0);
    check_val({name, "_hold_x"}, 32'(x_out), 32'd33);
    check_val({name, "_hold_y"}, 32'(y_out), 32'(top + 7'd3));
    check_val({name, "_hold_colour"}, 32'(colour), 32'b110);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    resetn       = 1'b0;
    frame_tick   = 1'b0;
    y_coordinate = 7'd0;

    #12;
    check_val("rst_plot", 32'(plot), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(frame_done), 32'd0);
    check_val("rst_x", 32'(x_out), 32'd0);
    check_val("rst_y", 32'(y_out), 32'd0);
    check_val("rst_colour", 32'(colour), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // First frame: draw only.
    run_frame("f60", 7'd60, 1'b0, 7'd0, 0, 0);
    // Move down one row: erase 60..63, draw 61..64.
    run_frame("f61", 7'd61, 1'b1, 7'd60, 0, 0);
    // Overshoot: clamped to 116, rows 116..119.
    run_frame("f121", 7'd121, 1'b1, 7'd61, 0, 0);
    // Ticks at k+5 and k+20 are dropped.
    run_frame("f70_drop", 7'd70, 1'b1, 7'd116, 5, 20);
    // Next tick after idle is normal.
    run_frame("f80", 7'd80, 1'b1, 7'd70, 0, 0);

    // Reset in the middle of the erase phase.
    @(negedge clk);
    y_coordinate = 7'd45;
    frame_tick   = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_val("mid_plot_before", 32'(plot), 32'd1);
    check_val("mid_colour_before", 32'(colour), 32'b000);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_val("mid_rst_plot", 32'(plot), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_x", 32'(x_out), 32'd0);
    check_val("mid_rst_y", 32'(y_out), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // After reset nothing to erase.
    run_frame("f40", 7'd40, 1'b0, 7'd0, 0, 0);
    run_frame("f50a", 7'd50, 1'b1, 7'd40, 0, 0);
    // Same position still erases and redraws.
    run_frame("f50b", 7'd50, 1'b1, 7'd50, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
